// File: rtl/nios_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : nios_div_cell
// Purpose  : Sequential radix-2 restoring divider, signed/unsigned, one bit/clk
// Revision : 1.0
// ============================================================================
module nios_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             A_div_start,
    input  logic             A_div_signed,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quotient,
    output logic [WIDTH-1:0] A_div_remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [CW-1:0]    r_cnt;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_dz;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic             w_accept;
    logic             w_last;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    assign w_accept = A_div_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Two's-complement negate of MIN wraps to 2^(WIDTH-1), the correct magnitude.
    assign w_neg_a  = A_div_signed & A_div_src1[WIDTH-1];
    assign w_neg_b  = A_div_signed & A_div_src2[WIDTH-1];
    assign w_abs_a  = w_neg_a ? (~A_div_src1 + 1'b1) : A_div_src1;
    assign w_abs_b  = w_neg_b ? (~A_div_src2 + 1'b1) : A_div_src2;

    // Partial remainder stays below |b| after each step, so WIDTH bits hold it;
    // only the shifted value needs the extra bit.
    assign w_shift  = {r_r, r_q[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_b});
    assign w_diff   = w_shift[WIDTH-1:0] - r_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (w_last)   w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_CALC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_dz    <= 1'b0;
            r_src1  <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= '0;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
                r_dz    <= (A_div_src2 == '0);
                r_src1  <= A_div_src1;
                r_b     <= w_abs_b;
                r_q     <= w_abs_a;
                r_r     <= '0;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_ge) begin
                    r_r <= w_diff;
                    r_q <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_r <= w_shift[WIDTH-1:0];
                    r_q <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else if (r_state == S_FIXUP) begin
                if (r_dz) begin
                    r_quot <= '1;
                    r_rem  <= r_src1;
                end else begin
                    r_quot <= (r_neg_a ^ r_neg_b) ? (~r_q + 1'b1) : r_q;
                    r_rem  <= r_neg_a ? (~r_r + 1'b1) : r_r;
                end
            end
        end
    end

    assign A_div_busy      = (r_state == S_CALC) || (r_state == S_FIXUP);
    assign A_div_done      = (r_state == S_DONE);
    assign A_div_quotient  = r_quot;
    assign A_div_remainder = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_nios_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_div_cell
// Purpose  : Directed vectors with a queued scoreboard and a done-driven monitor
// Revision : 1.0
// ============================================================================
module tb_nios_div_cell;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        int               cyc;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    nios_div_cell #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .A_div_start     (start),
        .A_div_signed    (sgn),
        .A_div_src1      (src1),
        .A_div_src2      (src2),
        .A_div_busy      (busy),
        .A_div_done      (done),
        .A_div_quotient  (quot),
        .A_div_remainder (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_q"},   {32'd0, quot}, {32'd0, e.q});
                chk({e.name, "_r"},   {32'd0, rem},  {32'd0, e.r});
                chk({e.name, "_cyc"}, 64'(cyc),      64'(e.cyc));
            end
        end
    end

    // Called at a negedge; the following posedge samples start.
    task automatic issue(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                         input string nm, input bit push);
        sgn   = s;
        src1  = a;
        src2  = b;
        start = 1'b1;
        if (push) sb.push_back('{q, r, cyc + LAT, nm});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk({nm, "_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic op(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input string nm);
        @(negedge clk);
        issue(s, a, b, q, r, nm, 1'b1);
        wait_empty(nm);
    endtask

    initial begin
        int nb;
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        sgn     = 1'b0;
        src1    = '0;
        src2    = '0;
        #2;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_q",    {32'd0, quot}, 64'd0);
        chk("rst_r",    {32'd0, rem},  64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic unsigned op with busy-window measurement.
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "u100_7", 1'b1);
        nb = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("busy_cycles", 64'(nb), 64'(WIDTH + 1));
        wait_empty("u100_7");

        op(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, "s_m7_2");
        op(1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         "s_7_m2");
        op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, "s_m7_m2");
        op(1'b1, 32'hFFFF_FFFA, 32'd3,          32'hFFFF_FFFE, 32'd0,         "s_m6_3");
        op(1'b0, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 32'd1,         "u_big_2");
        op(1'b1, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 32'h0000_1234, "s_dz");
        op(1'b0, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 32'h0000_1234, "u_dz");
        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         "s_min_m1");
        op(1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,         "u_max_1");

        // Start during CALC is ignored; start in DONE chains back-to-back.
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "ign_first", 1'b1);
        repeat (9) @(negedge clk);
        issue(1'b0, 32'd55, 32'd5, 32'd0, 32'd0, "ign_bogus", 1'b0);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("b2b_wait_done", 64'd0, 64'd1);
        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, "b2b_second", 1'b1);
        wait_empty("b2b");

        // Asynchronous reset mid-operation clears outputs and suppresses done.
        @(negedge clk);
        issue(1'b0, 32'h0000_1234, 32'd3, 32'd0, 32'd0, "aborted", 1'b0);
        repeat (14) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_q",    {32'd0, quot}, 64'd0);
        chk("abort_r",    {32'd0, rem},  64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("post_abort_busy", {63'd0, busy}, 64'd0);

        op(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, "after_reset");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
